cla_seq_add_ctrl: RTL and testbench
===================================

// Module: cla_seq_add_ctrl
// PURPOSE
// - Sequencer that time-multiplexes one 4-bit carry-lookahead slice (sum, group P/G) to perform
//   WIDTH-bit additions, one nibble per clock, LSB nibble first.
// - Carry between nibbles comes from a carry register updated from the slice group P/G.
// - Sits between an operand producer and a result consumer, with valid/ready on both sides.
// PARAMETERS
// - WIDTH   16  operand/result width; multiple of 4, minimum 8
// - NSLICE  WIDTH/4  nibble passes per operation (localparam, derived; not overridable)
// PORTS
// - clk        in   1      rising-edge clock
// - rst_n      in   1      asynchronous active-low reset
// - in_valid   in   1      operands valid
// - in_ready   out  1      block can accept operands (high only in IDLE)
// - a          in   WIDTH  operand A
// - b          in   WIDTH  operand B
// - cin        in   1      carry in to nibble 0
// - out_valid  out  1      result valid (high only in DONE)
// - out_ready  in   1      consumer accepts result
// - sum        out  WIDTH  result, registered
// - cout       out  1      carry out of MSB nibble, registered
// BEHAVIOUR
// - One clock (clk); reset asynchronous, active-low (rst_n).
// - Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, idx=0, carry=0.
// - Internal slice: a_n=a_q[4*idx+:4], b_n=b_q[4*idx+:4], c_in=carry.
//   Nibble carry-out = G | (P & carry).
// - FSM
//   - IDLE: in_ready=1. in_valid=1 -> latch a_q, b_q, carry<=cin; idx<=0; go RUN.
//   - RUN: in_ready=0. Each cycle: sum[4*idx+:4] <= slice sum; carry <= G|(P&carry);
//     idx <= idx+1. At idx==NSLICE-1, also cout <= G|(P&carry), then go DONE.
//   - DONE: out_valid=1; sum/cout held stable. out_ready=1 -> out_valid<=0; go IDLE.
// - Latency: accept edge at cycle k -> out_valid high from cycle k+NSLICE+1.
//   - NSLICE RUN cycles plus the DONE register stage.
// - Throughput: at most one operation per NSLICE+2 cycles.
//   - No accept in the DONE->IDLE cycle.
// - Boundaries
//   - in_valid during RUN/DONE: ignored; operands are not consumed.
//   - out_ready low in DONE: hold indefinitely; result unchanged.
//   - out_ready high outside DONE: no effect.
//   - Nibble sum bits not yet written in RUN: keep previous-operation values.
//     sum is defined only while out_valid=1.
//   - Full-width carry ripple (e.g. all-ones + 1): resolved one nibble per cycle via the
//     carry register; no combinational path across nibbles.
//   - rst_n low mid-RUN or mid-DONE: immediate return to reset values.
//     In-flight operation is discarded; no out_valid is produced for it.
//   - idx wraps only via the IDLE reload; never indexes beyond NSLICE-1.
// CONFIGURATION
// - Macro CLA_SEQ_SUB_EN
// - Defined: adds input port sub (1 bit) and output port ovf (1 bit, reset 0).
//   - sub is latched with the operands.
//   - sub=1 -> b_q <= ~b; carry <= 1 (cin ignored).
//   - ovf <= signed overflow of the MSB nibble: a_q[W-1]==b_q[W-1] && sum[W-1]!=a_q[W-1].
//     ovf is registered with cout.
//   - sub=0 -> identical to the undefined build; ovf still computed.
// - Undefined: no sub/ovf ports; plain addition only.
// TESTING (WIDTH=16)
// - 0x1234+0x4321, cin=0 -> sum=0x5555, cout=0; out_valid exactly 5 cycles after accept.
// - 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1 (carry through all 4 nibbles).
// - 0x0000+0x0000, cin=1 -> sum=0x0001, cout=0.
// - Back-to-back in_valid, out_ready held low 10 cycles -> second op not accepted; result stable.
//   out_ready high -> IDLE next cycle, second op accepted.
// - rst_n low during RUN idx=2 -> all outputs at reset values.
//   Next op 0x00FF+0x0001 -> 0x0100.
// - CLA_SEQ_SUB_EN: 0x0005-0x0007 -> 0xFFFE, cout=0, ovf=0.
//   CLA_SEQ_SUB_EN: 0x8000-0x0001 -> 0x7FFF, cout=1, ovf=1.

Source files
------------

// File: rtl/cla_seq_add_ctrl.sv
// Nibble-serial adder: one 4-bit carry-lookahead slice reused WIDTH/4 times.
// Optional subtract/overflow support is enabled by defining CLA_SEQ_SUB_EN.

module cla_seq_add_ctrl_slice (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       p_o,
    output logic       g_o
);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    always_comb begin
        p    = a_i ^ b_i;
        g    = a_i & b_i;
        c[0] = c_i;
        c[1] = g[0] | (p[0] & c_i);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_i);
        s_o  = p ^ c;
        p_o  = &p;
        g_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    end
endmodule

module cla_seq_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IW     = $clog2(NSLICE);
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW+1:0]    base;
    logic [3:0]       a_n;
    logic [3:0]       b_n;
    logic [3:0]       s_n;
    logic             p_n;
    logic             g_n;
    logic             c_n;
`ifdef CLA_SEQ_SUB_EN
    logic             ovf_q, ovf_d;
`endif

    always_comb begin
        base = {idx_q, 2'b00};
        a_n  = a_q[base +: 4];
        b_n  = b_q[base +: 4];
        c_n  = g_n | (p_n & carry_q);
    end

    cla_seq_add_ctrl_slice u_slice (
        .a_i (a_n),
        .b_i (b_n),
        .c_i (carry_q),
        .s_o (s_n),
        .p_o (p_n),
        .g_o (g_n)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
`ifdef CLA_SEQ_SUB_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
`ifdef CLA_SEQ_SUB_EN
                    if (sub) begin
                        b_d     = ~b;
                        carry_d = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                sum_d[base +: 4] = s_n;
                carry_d          = c_n;
                if (idx_q == LAST) begin
                    // idx parks on the last nibble; IDLE reloads it
                    cout_d  = c_n;
                    state_d = DONE;
`ifdef CLA_SEQ_SUB_EN
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                            && (s_n[3] != a_q[WIDTH-1]);
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef CLA_SEQ_SUB_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
`ifdef CLA_SEQ_SUB_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef CLA_SEQ_SUB_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// Directed bench for cla_seq_add_ctrl (WIDTH=16).
// Subtract vectors are exercised when CLA_SEQ_SUB_EN is defined.

module tb_cla_seq_add_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
`ifdef CLA_SEQ_SUB_EN
    logic        sub;
    logic        ovf;
    logic        exp_ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    cla_seq_add_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
        .sub       (sub),
        .ovf       (ovf),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles from the accept cycle (k) to the first DONE cycle.
    task automatic wait_done(output int n);
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] av,
                          input logic [15:0] bv, input logic cv,
                          input logic [15:0] es, input logic ec);
        int n;
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done(n);
        chk({tag, ".lat"}, n, 5);
        chk({tag, ".sum"}, sum, es);
        chk({tag, ".cout"}, cout, ec);
`ifdef CLA_SEQ_SUB_EN
        chk({tag, ".ovf"}, ovf, exp_ovf);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".ov_low"}, out_valid, 1'b0);
        chk({tag, ".ir_high"}, in_ready, 1'b1);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef CLA_SEQ_SUB_EN
        sub       = 1'b0;
        exp_ovf   = 1'b0;
`endif
        tick();
        tick();
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.sum", sum, 16'h0000);
        chk("rst.cout", cout, 1'b0);
        rst_n = 1'b1;
        tick();

        run_op("add1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_op("cin_only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
        run_op("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_or.out_valid", out_valid, 1'b0);
        chk("idle_or.in_ready", in_ready, 1'b1);

        a        = 16'h1111;
        b        = 16'h2222;
        cin      = 1'b0;
        in_valid = 1'b1;
        tick();
        a = 16'h0F0F;
        b = 16'h0101;
        wait_done(n);
        chk("b2b.lat1", n, 5);
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        chk("b2b.hold_ov", out_valid, 1'b1);
        chk("b2b.hold_ir", in_ready, 1'b0);
        chk("b2b.hold_sum", sum, 16'h3333);
        chk("b2b.hold_cout", cout, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("b2b.rel_ov", out_valid, 1'b0);
        chk("b2b.rel_ir", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("b2b.acc2", in_ready, 1'b0);
        wait_done(n);
        chk("b2b.lat2", n, 5);
        chk("b2b.sum2", sum, 16'h1010);
        chk("b2b.cout2", cout, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        a        = 16'hAAAA;
        b        = 16'h5555;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst.in_ready", in_ready, 1'b1);
        chk("midrst.out_valid", out_valid, 1'b0);
        chk("midrst.sum", sum, 16'h0000);
        chk("midrst.cout", cout, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        chk("midrst.no_ov", out_valid, 1'b0);
        run_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

`ifdef CLA_SEQ_SUB_EN
        sub     = 1'b1;
        exp_ovf = 1'b0;
        run_op("sub5m7", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
        exp_ovf = 1'b1;
        run_op("sub8000m1", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1);
        sub     = 1'b0;
        exp_ovf = 1'b1;
        run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
